// File: rtl/logic_unit_pipe_df.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both sides
// and a wrapping count of delivered results.
module logic_unit_pipe_df #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [CNT_W-1:0] count
);

   localparam logic [2:0] OpNot  = 3'b000;
   localparam logic [2:0] OpAnd  = 3'b001;
   localparam logic [2:0] OpOr   = 3'b010;
   localparam logic [2:0] OpXor  = 3'b011;
   localparam logic [2:0] OpNand = 3'b100;
   localparam logic [2:0] OpNor  = 3'b101;
   localparam logic [2:0] OpXnor = 3'b110;
   localparam logic [2:0] OpBuf  = 3'b111;

   logic             s1_valid_q;
   logic [2:0]       s1_op_q;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;
   logic             s2_valid_q;
   logic [WIDTH-1:0] s2_y_q;
   logic [CNT_W-1:0] count_q;

   logic             adv1;
   logic             adv2;
   logic             in_xfer;
   logic             out_xfer;
   logic [WIDTH-1:0] f_res;

   // Each stage may advance when it is empty or its successor is advancing.
   always_comb begin
      adv2     = !s2_valid_q || out_ready;
      adv1     = !s1_valid_q || adv2;
      in_xfer  = in_valid && adv1;
      out_xfer = s2_valid_q && out_ready;
   end

   always_comb begin
      f_res = '0;
      unique case (s1_op_q)
         OpNot:  f_res = ~s1_a_q;
         OpAnd:  f_res = s1_a_q & s1_b_q;
         OpOr:   f_res = s1_a_q | s1_b_q;
         OpXor:  f_res = s1_a_q ^ s1_b_q;
         OpNand: f_res = ~(s1_a_q & s1_b_q);
         OpNor:  f_res = ~(s1_a_q | s1_b_q);
         OpXnor: f_res = ~(s1_a_q ^ s1_b_q);
         OpBuf:  f_res = s1_a_q;
         default: f_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
      end else if (adv1) begin
         s1_valid_q <= in_valid;
         if (in_xfer) begin
            s1_op_q <= op;
            s1_a_q  <= a;
            s1_b_q  <= b;
         end
      end
   end

   // y holds its last value when a bubble moves into S2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_y_q     <= '0;
      end else if (adv2) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_y_q <= f_res;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (out_xfer) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign in_ready  = adv1;
   assign out_valid = s2_valid_q;
   assign y         = s2_y_q;
   assign count     = count_q;

endmodule

// File: tb/tb_logic_unit_pipe_df.sv
// Directed bench for logic_unit_pipe_df; a second instance with a 4-bit counter
// shares the stimulus to exercise counter wrap.
module tb_logic_unit_pipe_df;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [2:0] op = 3'b000;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;

   logic        in_ready, out_valid;
   logic [7:0]  y;
   logic [15:0] count;
   logic        in_ready_w, out_valid_w;
   logic [7:0]  y_w;
   logic [3:0]  count_w;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   logic_unit_pipe_df #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .count(count)
   );

   logic_unit_pipe_df #(.WIDTH(8), .CNT_W(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w), .op(op),
      .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready), .y(y_w),
      .count(count_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] ops_exp [8];
   logic [7:0] bp_vals [6];

   initial begin
      int ni;
      int ri;
      ops_exp = '{8'h0F, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0};
      bp_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      // Reset held with toggling inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         op        = 3'($urandom);
         a         = 8'($urandom);
         b         = 8'($urandom);
         #1;
         chk("rst_out_valid", 32'(out_valid), 0);
         chk("rst_y", 32'(y), 0);
         chk("rst_count", 32'(count), 0);
         chk("rst_in_ready", 32'(in_ready), 1);
         chk("rst_w_out_valid", 32'(out_valid_w), 0);
         chk("rst_w_y", 32'(y_w), 0);
         chk("rst_w_in_ready", 32'(in_ready_w), 1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;

      // Single NOT
      @(negedge clk);
      in_valid = 1'b1; op = 3'b000; a = 8'hA5; b = 8'h00;
      @(negedge clk);
      in_valid = 1'b0;
      chk("not_s1_no_out", 32'(out_valid), 0);
      @(negedge clk);
      chk("not_out_valid", 32'(out_valid), 1);
      chk("not_y", 32'(y), 32'h5A);
      @(negedge clk);
      chk("not_out_valid_once", 32'(out_valid), 0);
      chk("not_count", 32'(count), 1);

      // Stream all eight ops back to back
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            chk("ops_valid", 32'(out_valid), 1);
            chk("ops_y", 32'(y), 32'(ops_exp[c-2]));
         end
         in_valid = (c < 8);
         op = 3'(c); a = 8'hF0; b = 8'hCC;
      end
      @(negedge clk);
      chk("ops_drained", 32'(out_valid), 0);
      chk("ops_count", 32'(count), 9);

      // Backpressure: 6 transactions, consumer stalls for cycles 3..7
      ni = 0;
      ri = 0;
      for (int c = 0; c < 30 && ri < 6; c++) begin
         @(negedge clk);
         out_ready = !(c >= 3 && c <= 7);
         in_valid = (ni < 6);
         op = 3'b001; b = 8'hFF;
         a = (ni < 6) ? bp_vals[ni] : 8'h00;
         #1;
         if (c == 5) begin
            chk("bp_in_ready_low", 32'(in_ready), 0);
            chk("bp_held_valid", 32'(out_valid), 1);
            chk("bp_held_y", 32'(y), 32'h22);
         end
         if (out_valid) begin
            chk("bp_order_y", 32'(y), 32'(bp_vals[ri]));
            if (out_ready) ri++;
         end
         if (in_valid && in_ready) ni++;
      end
      chk("bp_all_delivered", 32'(ri), 6);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_no_extra", 32'(out_valid), 0);
      chk("bp_count", 32'(count), 15);

      // Reset with two results in flight
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; op = 3'b000; a = 8'h01;
      @(negedge clk);
      a = 8'h02;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_two_in_flight", 32'(out_valid), 1);
      chk("mid_in_ready_low", 32'(in_ready), 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; op = 3'b010; a = 8'h3C; b = 8'h81;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 1);
      chk("post_rst_y", 32'(y), 32'hBD);
      @(negedge clk);
      chk("post_rst_count", 32'(count), 1);

      // 16 more results: 17 since reset, the 4-bit counter wraps to 1
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         in_valid = 1'b1; op = 3'b111; a = 8'(c);
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("wrap_count_w", 32'(count_w), 1);
      chk("wrap_count_main", 32'(count), 17);
      chk("wrap_last_y", 32'(y), 32'h0F);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
